// File: rtl/ascon_perm_iter.sv
// ---------------------------------------------------------------------------
// ascon_perm_iter
// Iterative ASCON permutation (p^a / p^b), one round per clock over the
// 320-bit state. A state is captured on an accepted start. ROUNDS_A or
// ROUNDS_B rounds are then applied. The result is held until the next start.
// Rounds always finish at round index 11, so p^b starts at 12-ROUNDS_B.
//
// Ports
//   clock_i  : system clock, rising edge
//   reset_i  : synchronous, active-high reset
//   start_i  : load state_i and begin a permutation (IDLE or DONE only)
//   mode_i   : sampled with start_i; 0 = p^a, 1 = p^b
//   state_i  : 320-bit state {x0,x1,x2,x3,x4}, x0 in the MSBs
//   busy_o   : rounds executing
//   done_o   : one-cycle pulse, state_o holds the final permuted state
//   round_o  : round index applied on the next edge (0 outside RUN)
//   state_o  : state register contents
// ---------------------------------------------------------------------------
module ascon_perm_iter #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [319:0] state_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [3:0]   round_o,
  output logic [319:0] state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e         fsm_q,   fsm_d;
  logic [319:0] state_q, state_d;
  logic [3:0]   cnt_q,   cnt_d;
  logic         accept;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] round_fn(input logic [319:0] s,
                                            input logic [3:0]   r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [7:0]  c;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    // Round constant c[r] = F0 - r*0F, added into the low byte of x2.
    c  = 8'hF0 - (8'(r) * 8'h0F);
    x2[7:0] = x2[7:0] ^ c;
    // Bitsliced 5-bit S-box (chi-like core with input/output mixing).
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // Linear diffusion layer.
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Start is honoured in IDLE and in DONE (back-to-back), never in RUN.
  assign accept = start_i && (fsm_q == IDLE || fsm_q == DONE);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      RUN: begin
        state_d = round_fn(state_q, cnt_q);
        if (cnt_q == 4'd11) begin
          fsm_d = DONE;
          cnt_d = 4'd0;   // round_o reads 0 outside RUN
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    if (accept) begin
      fsm_d   = RUN;
      state_d = state_i;
      cnt_d   = mode_i ? 4'(12 - ROUNDS_B) : 4'(12 - ROUNDS_A);
    end
  end

  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o  = (fsm_q == RUN);
  assign done_o  = (fsm_q == DONE);
  assign round_o = cnt_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// ---------------------------------------------------------------------------
// tb_ascon_perm_iter
// Self-checking bench for ascon_perm_iter. The reference model applies the
// S-box as a 32-entry lookup table per bit column. Round constants are
// computed arithmetically. A downstream key-XOR stage, enabled by done_o,
// is modelled in the bench and its output is checked as well.
// ---------------------------------------------------------------------------
module tb_ascon_perm_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         mode;
  logic [319:0] state_in;
  logic         busy;
  logic         done;
  logic [3:0]   round;
  logic [319:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] key;
  logic [319:0] ks_q;   // downstream key-XOR stage output

  ascon_perm_iter #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
    .clock_i (clk),
    .reset_i (reset),
    .start_i (start),
    .mode_i  (mode),
    .state_i (state_in),
    .busy_o  (busy),
    .done_o  (done),
    .round_o (round),
    .state_o (state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (done) ks_q <= state_out ^ {192'h0, key};

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  task automatic check(input string tag, input logic [319:0] got,
                       input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] s, input int i);
    logic [63:0] x [5];
    logic [4:0]  col, v;
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
    x[2][7:0] = x[2][7:0] ^ 8'((240 - 15 * i) & 255);
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      v   = SBOX[col];
      for (int k = 0; k < 5; k++) x[k][b] = v[4 - k];
    end
    for (int k = 0; k < 5; k++)
      x[k] = x[k] ^ rotr(x[k], ROT_A[k]) ^ rotr(x[k], ROT_B[k]);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
    logic [319:0] r = s;
    for (int i = 12 - n; i < 12; i++) r = model_round(r, i);
    return r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Single permutation from IDLE; checks timing, round index, first round,
  // final result and the downstream key-XOR output.
  task automatic do_perm(input logic [319:0] s, input logic m, input string tag);
    int n = m ? 6 : 12;
    int busy_cnt = 0;
    int cyc;
    logic seen = 1'b0;
    logic [319:0] exp = model_perm(s, n);
    @(negedge clk);
    start = 1'b1; mode = m; state_in = s;
    @(negedge clk);
    start = 1'b0; state_in = rand_state();
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) begin
        busy_cnt++;
        check({tag, "_round"}, 320'(round), 320'(12 - n + cyc - 1));
      end
      if (cyc == 2) check({tag, "_first_round"}, state_out, model_round(s, 12 - n));
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 320'(seen), 320'(1));
    check({tag, "_latency"}, 320'(cyc), 320'(n + 1));
    check({tag, "_busy_cycles"}, 320'(busy_cnt), 320'(n));
    check({tag, "_result"}, state_out, exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, 320'({busy, done}), 320'(0));
    check({tag, "_hold"}, state_out, exp);
    check({tag, "_keyxor"}, ks_q, exp ^ {192'h0, key});
  endtask

  initial begin
    logic [319:0] a, b;
    int gap;
    int t;
    reset = 1'b1; start = 1'b0; mode = 1'b0; state_in = '0; key = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_ctrl", 320'({busy, done, round}), 320'(0));
      check("reset_state", state_out, 320'h0);
    end

    // p12 on the ASCON-128 IV with zero key and nonce.
    do_perm({64'h80400c0600000000, 256'h0}, 1'b0, "p12_iv");
    // p6 on all-zero state: first constant is 96.
    do_perm(320'h0, 1'b1, "p6_zero");

    // Back-to-back with start held high throughout.
    a = rand_state(); b = rand_state();
    @(negedge clk);
    start = 1'b1; mode = 1'b0; state_in = a;
    gap = 0; t = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      gap++;
      if (done) begin
        t++;
        if (t == 1) begin
          check("b2b_first", state_out, model_perm(a, 12));
          check("b2b_first_gap", 320'(gap), 320'(13));
          state_in = b;
          gap = 0;
        end else begin
          check("b2b_second", state_out, model_perm(b, 12));
          check("b2b_period", 320'(gap), 320'(13));
          start = 1'b0;
          break;
        end
      end else if (gap > 1) begin
        state_in = rand_state();   // must be ignored while running
      end
    end
    check("b2b_two_dones", 320'(t), 320'(2));
    @(negedge clk);
    check("b2b_idle", 320'({busy, done}), 320'(0));

    // Reset after 5 rounds.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; state_in = rand_state();
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", 320'(busy), 320'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_ctrl", 320'({busy, done, round}), 320'(0));
    check("mid_reset_state", state_out, 320'h0);
    t = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) t++;
    end
    check("mid_reset_quiet", 320'(t), 320'(0));
    do_perm(rand_state(), 1'b0, "post_reset");

    // Random states, both modes.
    for (int r = 0; r < 1000; r++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      do_perm(rand_state(), 1'($urandom_range(0, 1)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
